// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM request stream and buffers the
// returned words, each tagged with its PC, for decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   demand;

  // Credit check counts the word already in flight and frees the slot being
  // popped this cycle, so a returning word always finds room in the buffer.
  always_comb begin
    pop    = instr_valid & instr_ready;
    push   = inflight & ~redirect_valid;
    demand = {1'b0, occ} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue  = ~rst & ~redirect_valid & (demand < DEPTH_C);
  end

  assign rom_req     = issue;
  assign rom_addr    = fetch_pc;
  assign instr_valid = ~rst & (occ != '0);
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_instr[wr_ptr] <= rom_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model, directed latency/redirect/reset scenarios,
// then random traffic checked against an expected sequential instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   rom_word = 32'h10012537;
      32'h4:   rom_word = 32'h00052583;
      32'h8:   rom_word = 32'h00b52223;
      32'hC:   rom_word = 32'hffdfedef;
      default: rom_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always @(posedge clk) rom_rdata <= rom_req ? rom_word(rom_addr) : $urandom;

  // Expected stream: consecutive words starting at the latest fetch target.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_from(input logic [31:0] target);
    logic [31:0] a;
    a = target & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back('{pc: a, word: rom_word(a)});
      a = a + 32'd4;
    end
  endtask

  bit          mon_en = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_instr, hold_pc;
  int          stall = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (rst || redirect_valid) chk("req_blocked", {31'b0, rom_req}, 32'h0);
      chk("addr_align", {30'b0, rom_addr[1:0]}, 32'h0);
      if (hold_prev && !rst) begin
        chk("hold_valid", {31'b0, instr_valid}, 32'h1);
        chk("hold_instr", instr, hold_instr);
        chk("hold_pc", instr_pc, hold_pc);
      end
      if (instr_valid && instr_ready && !redirect_valid && !rst) begin
        stall = 0;
        if (exp_q.size() == 0) fail_event("scoreboard_underflow");
        else begin
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_instr", instr, e.word);
        end
      end else if (instr_ready && !redirect_valid && !rst) begin
        stall++;
        if (stall > 8) begin
          fail_event("stall_no_delivery");
          stall = 0;
        end
      end else begin
        stall = 0;
      end
      hold_prev  = instr_valid && !instr_ready && !redirect_valid && !rst;
      hold_instr = instr;
      hold_pc    = instr_pc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    redirect_valid = 1'b0;
    expect_from(RESET_PC);
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    expect_from(target);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    if (!instr_valid) fail_event(name);
  endtask

  initial begin
    mon_en = 1'b1;

    // 1: reset release with ready high, back-to-back delivery
    instr_ready = 1'b1;
    do_reset(2);
    #1;
    chk("t1_req_c0", {31'b0, rom_req}, 32'h1);
    chk("t1_addr_c0", rom_addr, RESET_PC);
    chk("t1_valid_c0", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("t1_valid_c1", {31'b0, instr_valid}, 32'h0);
    chk("t1_addr_c1", rom_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", {31'b0, instr_valid}, 32'h1);
      chk("t1_pc", instr_pc, 32'(i * 4));
      chk("t1_instr", instr, rom_word(32'(i * 4)));
    end

    // 2: ready low fills the buffer, request stops, resumes without gap
    instr_ready = 1'b0;
    do_reset(2);
    #1;
    chk("t2_req_c0", {31'b0, rom_req}, 32'h1);
    tick();
    chk("t2_addr_c1", rom_addr, 32'h4);
    tick();
    chk("t2_req_full_c2", {31'b0, rom_req}, 32'h0);
    tick();
    chk("t2_req_full_c3", {31'b0, rom_req}, 32'h0);
    chk("t2_head_pc", instr_pc, 32'h0);
    tick();
    instr_ready = 1'b1;
    #1;
    chk("t2_req_resume", {31'b0, rom_req}, 32'h1);
    chk("t2_addr_resume", rom_addr, 32'h8);
    repeat (6) tick();

    // 3: redirect to 0x4 while 0xC is in flight
    do_reset(2);
    repeat (4) tick();
    do_redirect(32'h4);
    #1;
    chk("t3_req", {31'b0, rom_req}, 32'h1);
    chk("t3_addr", rom_addr, 32'h4);
    wait_valid("t3_wait_valid_timeout");
    chk("t3_pc", instr_pc, 32'h4);
    chk("t3_instr", instr, 32'h00052583);
    repeat (3) tick();

    // 4: misaligned redirect target is forced to word alignment
    do_redirect(32'h6);
    #1;
    chk("t4_addr", rom_addr, 32'h4);
    wait_valid("t4_wait_valid_timeout");
    chk("t4_pc", instr_pc, 32'h4);

    // 5: redirect coincides with pop of pc 0x8
    do_reset(2);
    repeat (4) tick();
    chk("t5_head_pc", instr_pc, 32'h8);
    do_redirect(32'h40);
    #1;
    chk("t5_valid_after", {31'b0, instr_valid}, 32'h0);
    chk("t5_addr", rom_addr, 32'h40);
    wait_valid("t5_wait_valid_timeout");
    chk("t5_pc", instr_pc, 32'h40);

    // 6: reset mid-stream
    repeat (5) tick();
    rst = 1'b1;
    expect_from(RESET_PC);
    tick();
    chk("t6_valid_rst", {31'b0, instr_valid}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid_release", {31'b0, instr_valid}, 32'h0);
    chk("t6_addr_release", rom_addr, RESET_PC);
    wait_valid("t6_wait_valid_timeout");
    chk("t6_pc", instr_pc, RESET_PC);

    // PC wrap at top of address space
    do_redirect(32'hFFFF_FFFC);
    #1;
    chk("wrap_addr0", rom_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", rom_addr, 32'h0);
    wait_valid("wrap_wait_valid_timeout");
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    repeat (4) tick();

    // Random traffic: ready throttling, redirects (some back-to-back), resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      r = $urandom_range(0, 199);
      if (rst) begin
        rst = ($urandom_range(0, 1) == 0);
        redirect_valid = 1'b0;
      end else if (r == 0) begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        expect_from(RESET_PC);
      end else if (r < 10) begin
        redirect_valid = 1'b1;
        expect_from(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
    end

    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (5) tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
